// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, word size and PC state encoding.
package cpu_defs;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0180;
    localparam int unsigned WORD_BYTES   = 4;

    typedef enum logic [0:0] {
        RESET_HOLD,
        RUN
    } pc_state_t;

endpackage

// File: rtl/mux_2x1.sv
// Generic 2:1 select; sel_i=1 picks d1_i.
module mux_2x1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/pc_next_calc.sv
// Combinational next-PC computation: sequential, branch and jump targets plus the
// jr > jump > branch > pc+4 priority chain built from cascaded 2:1 selects.
module pc_next_calc
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] branch_off;
    logic [WIDTH-1:0] sel_branch;
    logic [WIDTH-1:0] sel_jump;

    assign pc_plus4      = pc + WIDTH'(WORD_BYTES);
    assign branch_off    = {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00};

    // Lowest priority first; each later stage overrides the earlier choice.
    mux_2x1 #(.WIDTH(WIDTH)) u_mux_branch (
        .d0_i  (pc_plus4),
        .d1_i  (branch_target),
        .sel_i (branch_taken),
        .y_o   (sel_branch)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_mux_jump (
        .d0_i  (sel_branch),
        .d1_i  (jump_target),
        .sel_i (jump),
        .y_o   (sel_jump)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_mux_jr (
        .d0_i  (sel_jump),
        .d1_i  (jr_target),
        .sel_i (jr),
        .y_o   (next_pc)
    );

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: PC register with stall hold, reset vector,
// misaligned-target trap to EXC_VECTOR and EPC capture.
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = cpu_defs::RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = cpu_defs::EXC_VECTOR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             addr_err,
    output logic [WIDTH-1:0] epc
);
    import cpu_defs::*;

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             addr_err_q, addr_err_d;

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;

    pc_next_calc #(.WIDTH(WIDTH)) u_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d    = RUN;
        pc_d       = pc_q;
        epc_d      = epc_q;
        addr_err_d = 1'b0;
        // The first edge out of reset only validates the PC; it does not advance it.
        if (state_q == RUN && !stall) begin
            if (next_pc[1:0] != 2'b00) begin
                pc_d       = WIDTH'(EXC_VECTOR);
                epc_d      = next_pc;
                addr_err_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_HOLD;
            pc_q       <= WIDTH'(RESET_VECTOR);
            epc_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);
    assign addr_err = addr_err_q;
    assign epc      = epc_q;

    // Branch/jump targets are word-aligned by construction; only jr can trap.
    logic unused_targets;
    assign unused_targets = ^{branch_target, jump_target};

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random control traffic
// compared against an arithmetic reference model of the fetch PC.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc, pc_plus4, epc;
    logic        pc_valid, addr_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_epc = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_valid     (pc_valid),
        .addr_err     (addr_err),
        .epc          (epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".valid"}, 32'(pc_valid), 32'(m_valid));
        chk({tag, ".err"}, 32'(addr_err), 32'(m_err));
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".plus4"}, pc_plus4, m_pc + 32'd4);
    endtask

    function automatic logic [31:0] model_next();
        longint unsigned pp;
        longint signed   off;
        pp = longint'(m_pc) + 4;
        if (jr) return jr_target;
        if (jump) return {pp[31:28], jump_index, 2'b00};
        if (branch_taken) begin
            off = longint'($signed(branch_imm)) * 4;
            return 32'(pp + longint'(off));
        end
        return 32'(pp);
    endfunction

    // Apply inputs, advance the model and the DUT by one edge, check #1 after the edge.
    task automatic step(input string tag, input logic s, input logic br, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx, input logic r,
                        input logic [31:0] tgt);
        logic [31:0] n;
        stall = s; branch_taken = br; branch_imm = imm;
        jump = j; jump_index = idx; jr = r; jr_target = tgt;
        n = model_next();
        m_err = 1'b0;
        if (!m_valid) begin
            m_valid = 1'b1;
        end else if (!s) begin
            if (n % 4 != 0) begin
                m_epc = n;
                m_pc  = 32'h180;
                m_err = 1'b1;
            end else begin
                m_pc = n;
            end
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic go_jr(input string tag, input logic [31:0] tgt);
        step(tag, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, tgt);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_pc = 32'h0; m_epc = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        #1;
        chk_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset release
        #12;
        chk_all("reset");
        @(posedge clk);
        #1;
        chk_all("reset_hold");
        rst_n = 1'b1;
        idle("first_edge");
        idle("seq4");
        idle("seq8");
        idle("seq12");

        // Branch backward and forward
        go_jr("to_100", 32'h100);
        step("br_back", 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("br_back_val", pc, 32'h0FC);
        step("br_fwd", 1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("br_fwd_val", pc, 32'h10C);

        // Priority and jump
        go_jr("to_jseg", 32'h1000_0040);
        step("prio_all", 1'b0, 1'b1, 16'h0010, 1'b1, 26'h10, 1'b1, 32'h200);
        chk("prio_val", pc, 32'h200);
        go_jr("to_jseg2", 32'h1000_0040);
        step("jump", 1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0);
        chk("jump_val", pc, 32'h1000_0040);

        // Stall overrides jump, then jump is taken
        go_jr("to_20", 32'h20);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0);
        chk("stall_val", pc, 32'h20);
        step("unstall_jump", 1'b0, 1'b0, 16'h0, 1'b1, 26'h40, 1'b0, 32'h0);
        chk("unstall_val", pc, 32'h100);

        // Misaligned jr trap
        go_jr("trap", 32'h0000_0206);
        chk("trap_pc", pc, 32'h180);
        chk("trap_epc", epc, 32'h206);
        chk("trap_err", 32'(addr_err), 32'd1);
        idle("after_trap");
        chk("after_trap_pc", pc, 32'h184);

        // Trap while already at the exception vector
        go_jr("to_exc", 32'h180);
        go_jr("trap_at_exc", 32'h0000_0181);

        // Wrap
        go_jr("to_top", 32'hFFFF_FFFC);
        idle("wrap");
        chk("wrap_val", pc, 32'h0);

        // Async reset mid-cycle, mid-trap
        go_jr("to_trap2", 32'h0000_0303);
        async_reset("areset_trap");
        idle("post_reset_edge");
        idle("post_reset_seq");

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step("rand", ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 26'($urandom), ($urandom_range(0, 4) == 0), tgt);
        end

        // Async reset during a stall
        stall = 1'b1;
        async_reset("areset_stall");
        idle("post_reset2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-stage program counter for the single-cycle MIPS core.
- Holds the PC register and computes the next PC from PC+4, branch, jump and jump-register sources.
- Its next-PC selection chain is built from 2:1 selects, and it drives the instruction memory address.
- Adds stall hold, reset vector, misaligned-target trapping and an EPC capture register.

Parameters:
- WIDTH, 32, PC/data width in bits; only 32 is supported.
- RESET_VECTOR, 32'h0000_0000, PC value on reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded when a misaligned target is trapped.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC; no update this cycle.
- branch_taken  input  1  branch condition true (from control/ALU zero).
- branch_imm  input  16  raw I-type immediate.
- jump  input  1  J/JAL instruction.
- jump_index  input  26  instr[25:0].
- jr  input  1  JR/JALR instruction.
- jr_target  input  WIDTH  rs register value.
- pc  output  WIDTH  current PC, to instruction memory.
- pc_plus4  output  WIDTH  pc+4, combinational; used as the JAL link value.
- pc_valid  output  1  PC holds a fetchable address.
- addr_err  output  1  one-cycle pulse: a misaligned target was trapped.
- epc  output  WIDTH  faulting target address of the last trap.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_VECTOR, pc_valid=0, addr_err=0, epc=0. Takes effect immediately, including mid-stall or mid-trap.
- pc_valid: goes to 1 on the first rising edge after rst_n deasserts and stays 1 until the next reset. pc does not advance on that first edge; it still shows RESET_VECTOR. The PC update rules below apply only while pc_valid=1.
- pc_plus4 = pc + 4, computed modulo 2^32 (0xFFFF_FFFC wraps to 0).
- branch_target = pc_plus4 + (sign_extend(branch_imm) << 2), computed modulo 2^32.
- jump_target = {pc_plus4[31:28], jump_index, 2'b00}.
- next_pc priority, highest first: jr → jr_target; jump → jump_target; branch_taken → branch_target; otherwise pc_plus4. Simultaneous requests resolve by this priority.
- Per clock edge, with pc_valid=1:
  - stall=1: pc, epc unchanged; addr_err=0. Stall overrides every redirect, and the redirect request is not remembered.
  - stall=0 and next_pc[1:0]!=0: pc ← EXC_VECTOR, epc ← next_pc, addr_err=1 for exactly that one cycle.
  - Otherwise: pc ← next_pc; addr_err=0.
- Only jr_target can be misaligned; the other sources are word-aligned by construction.
- Latency: the redirect decision made in cycle N appears on pc in cycle N+1. There is no delay slot.
- State machine (2 states):
  - RESET_HOLD → RUN on the first edge with rst_n high.
  - RUN persists.
  - Any rst_n low → RESET_HOLD.
- The trap is not a separate state; it is a single-edge redirect.
- A trap while already at EXC_VECTOR is handled normally.

Decomposition:
- Shared package (cpu_defs): RESET_VECTOR, EXC_VECTOR, WORD_BYTES=4, and the pc_state_t enum {RESET_HOLD, RUN}.
- The next-PC priority chain is three cascaded instances of the existing mux_2x1 (WIDTH=32): branch vs pc+4, then jump, then jr.
- Natural sub-module: pc_next_calc. It is combinational and produces pc_plus4, branch_target, jump_target and next_pc. The pc_unit top keeps all sequential state.

Test Plan:
- Reset release: hold rst_n=0, then release. Required: pc=0, pc_valid=0 during reset; pc_valid=1 after the first edge; pc=4, 8, 12 on the following edges with no control inputs.
- Branch: at pc=0x100 with branch_taken=1, branch_imm=16'hFFFE. Required: next pc=0x0FC. Then branch_imm=16'h0003 at pc=0x0FC. Required: next pc=0x10C.
- Priority and jump: at pc=0x1000_0040, assert jr=1 (jr_target=0x200), jump=1 (jump_index=26'h10) and branch_taken=1 together. Required: pc=0x200. Then at pc=0x1000_0040 with jump=1 alone, jump_index=26'h10. Required: pc=0x1000_0040 ({pc_plus4[31:28], jump_index, 2'b00}).
- Stall: stall=1 for 3 cycles at pc=0x20 with jump asserted. Required: pc stays 0x20, addr_err=0. After stall deasserts with jump still high, pc takes jump_target.
- Misaligned jr: jr=1, jr_target=0x0000_0206. Required: pc=0x180, epc=0x206, addr_err=1 for exactly one cycle, then pc=0x184.
- Wrap and async reset: at pc=0xFFFF_FFFC. Required: next pc=0. Asserting rst_n=0 mid-cycle must force pc=0 and pc_valid=0 before the next edge.
